// File: rtl/spi_cmd_pkg.sv
// Shared opcodes, sequencer states and status-byte layout for the SPI command controller.
package spi_cmd_pkg;

  localparam logic [7:0] OP_NOP    = 8'h00;
  localparam logic [7:0] OP_WRITE  = 8'h01;
  localparam logic [7:0] OP_READ   = 8'h02;
  localparam logic [7:0] OP_STATUS = 8'h03;
  localparam logic [7:0] OP_CLEAR  = 8'h04;

  typedef enum logic [2:0] {
    IDLE,
    ADDR_HI,
    ADDR_LO,
    WDATA,
    RDATA,
    STAT,
    DISCARD
  } state_e;

  localparam int unsigned STAT_ERR_BIT  = 0;
  localparam int unsigned STAT_OVR_BIT  = 1;
  localparam int unsigned STAT_BUSY_BIT = 2;

  // Pack the status reply byte; unused bits read as zero.
  function automatic logic [7:0] status_byte(input logic busy, input logic ovr, input logic err);
    logic [7:0] s;
    s                = '0;
    s[STAT_BUSY_BIT] = busy;
    s[STAT_OVR_BIT]  = ovr;
    s[STAT_ERR_BIT]  = err;
    return s;
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for a single asynchronous level into clk_sys.
module sync_2ff #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk_sys,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk_sys) begin
    if (rst) begin
      meta <= RST_VAL;
      q    <= RST_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/spi_cmd_ctrl.sv
// SPI packet parser that turns received bytes into single-beat register/framebuffer
// bus accesses with address auto-increment, and returns read/status bytes to spi_slave.
module spi_cmd_ctrl
  import spi_cmd_pkg::*;
#(
  parameter int unsigned ADDR_W      = 16,
  parameter int unsigned ACK_TIMEOUT = 64
) (
  input  logic              clk_sys,
  input  logic              rst,
  input  logic              cs_n,
  input  logic              rx_ready,
  input  logic [7:0]        rx_data,
  output logic [7:0]        tx_data,
  output logic              bus_req,
  output logic              bus_we,
  output logic [ADDR_W-1:0] bus_addr,
  output logic [7:0]        bus_wdata,
  input  logic              bus_ack,
  input  logic [7:0]        bus_rdata,
  output logic              busy
);

  localparam int unsigned     CNT_W    = $clog2(ACK_TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ACK_TIMEOUT - 1);

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic                is_read_q, is_read_d;
  logic                err_q, err_d;
  logic                ovr_q, ovr_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [7:0]          tx_d;
  logic                req_d, we_d, busy_d;
  logic [ADDR_W-1:0]   baddr_d;
  logic [7:0]          wdata_d;

  logic cs_n_sync, cs_active;
  logic ack_c, tmo_c, rx_c, ovr_c, byte_c;

  sync_2ff #(.RST_VAL(1'b1)) u_cs_sync (
    .clk_sys (clk_sys),
    .rst     (rst),
    .d       (cs_n),
    .q       (cs_n_sync)
  );

  // An ack retires before a coincident byte is judged, so that byte is not an overrun.
  assign cs_active = ~cs_n_sync;
  assign ack_c     = bus_req & bus_ack;
  assign tmo_c     = bus_req & ~bus_ack & (cnt_q == CNT_LAST);
  assign rx_c      = rx_ready & cs_active;
  assign ovr_c     = rx_c & bus_req & ~bus_ack;
  assign byte_c    = rx_c & ~ovr_c;

  always_ff @(posedge clk_sys) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (!cs_active) begin
      state_d = IDLE;
    end else if (tmo_c) begin
      state_d = DISCARD;
    end else if (byte_c) begin
      case (state_q)
        IDLE: begin
          case (rx_data)
            OP_NOP, OP_CLEAR:  state_d = IDLE;
            OP_WRITE, OP_READ: state_d = ADDR_HI;
            OP_STATUS:         state_d = STAT;
            default:           state_d = DISCARD;
          endcase
        end
        ADDR_HI: state_d = ADDR_LO;
        ADDR_LO: state_d = is_read_q ? RDATA : WDATA;
        default: state_d = state_q;
      endcase
    end
  end

  always_comb begin
    addr_d    = addr_q;
    is_read_d = is_read_q;
    err_d     = err_q;
    ovr_d     = ovr_q;
    cnt_d     = cnt_q;
    tx_d      = tx_data;
    req_d     = bus_req;
    we_d      = bus_we;
    baddr_d   = bus_addr;
    wdata_d   = bus_wdata;

    if (bus_req) cnt_d = cnt_q + CNT_W'(1);

    if (ack_c) begin
      req_d  = 1'b0;
      addr_d = addr_q + ADDR_W'(1);
      if (!bus_we && state_q == RDATA) tx_d = bus_rdata;
    end
    if (tmo_c) begin
      req_d = 1'b0;
      err_d = 1'b1;
    end
    if (ovr_c) ovr_d = 1'b1;

    if (byte_c) begin
      case (state_q)
        IDLE: begin
          case (rx_data)
            OP_WRITE: is_read_d = 1'b0;
            OP_READ:  is_read_d = 1'b1;
            OP_CLEAR: begin
              err_d = 1'b0;
              ovr_d = 1'b0;
            end
            OP_NOP, OP_STATUS: ;
            default:  err_d = 1'b1;
          endcase
        end
        ADDR_HI: addr_d = ADDR_W'({rx_data, addr_q[7:0]});
        ADDR_LO: begin
          addr_d = {addr_q[ADDR_W-1:8], rx_data};
          if (is_read_q) begin
            req_d   = 1'b1;
            we_d    = 1'b0;
            baddr_d = addr_d;
            cnt_d   = '0;
          end
        end
        WDATA: begin
          req_d   = 1'b1;
          we_d    = 1'b1;
          baddr_d = addr_d;
          wdata_d = rx_data;
          cnt_d   = '0;
        end
        RDATA: begin
          req_d   = 1'b1;
          we_d    = 1'b0;
          baddr_d = addr_d;
          cnt_d   = '0;
        end
        default: ;
      endcase
    end

    // The FSM is always non-IDLE here, so the busy bit reports bus activity instead.
    if (state_q == STAT) tx_d = status_byte(bus_req, ovr_q, err_q);
    if (!cs_active)      tx_d = '0;

    busy_d = (state_d != IDLE) | req_d;
  end

  always_ff @(posedge clk_sys) begin
    if (rst) begin
      addr_q    <= '0;
      is_read_q <= 1'b0;
      err_q     <= 1'b0;
      ovr_q     <= 1'b0;
      cnt_q     <= '0;
      tx_data   <= '0;
      bus_req   <= 1'b0;
      bus_we    <= 1'b0;
      bus_addr  <= '0;
      bus_wdata <= '0;
      busy      <= 1'b0;
    end else begin
      addr_q    <= addr_d;
      is_read_q <= is_read_d;
      err_q     <= err_d;
      ovr_q     <= ovr_d;
      cnt_q     <= cnt_d;
      tx_data   <= tx_d;
      bus_req   <= req_d;
      bus_we    <= we_d;
      bus_addr  <= baddr_d;
      bus_wdata <= wdata_d;
      busy      <= busy_d;
    end
  end

endmodule

// File: tb/tb_spi_cmd_ctrl.sv
// Directed and randomized frames against a transaction-level model of spi_cmd_ctrl.
module tb_spi_cmd_ctrl;

  localparam int unsigned ADDR_W      = 16;
  localparam int unsigned ACK_TIMEOUT = 64;
  localparam int          GAP         = 16;

  logic              clk_sys = 1'b0;
  logic              rst;
  logic              cs_n;
  logic              rx_ready;
  logic [7:0]        rx_data;
  logic [7:0]        tx_data;
  logic              bus_req;
  logic              bus_we;
  logic [ADDR_W-1:0] bus_addr;
  logic [7:0]        bus_wdata;
  logic              bus_ack;
  logic [7:0]        bus_rdata;
  logic              busy;

  spi_cmd_ctrl #(.ADDR_W(ADDR_W), .ACK_TIMEOUT(ACK_TIMEOUT)) dut (
    .clk_sys   (clk_sys),
    .rst       (rst),
    .cs_n      (cs_n),
    .rx_ready  (rx_ready),
    .rx_data   (rx_data),
    .tx_data   (tx_data),
    .bus_req   (bus_req),
    .bus_we    (bus_we),
    .bus_addr  (bus_addr),
    .bus_wdata (bus_wdata),
    .bus_ack   (bus_ack),
    .bus_rdata (bus_rdata),
    .busy      (busy)
  );

  always #5 clk_sys = ~clk_sys;

  typedef struct packed {
    logic        we;
    logic [15:0] addr;
    logic [7:0]  wdata;
  } txn_t;

  txn_t       obs_q[$];
  txn_t       exp_q[$];
  logic [7:0] wbuf[$];
  logic [7:0] mem[65536];
  int         ack_delay;
  bit         ack_en;
  bit         m_err, m_ovr;
  int         checks   = 0;
  int         failures = 0;

  // Bus slave: acks each request after ack_delay cycles and logs what it saw.
  initial begin : responder
    int   cnt;
    txn_t t;
    cnt       = 0;
    bus_ack   = 1'b0;
    bus_rdata = 8'h00;
    forever begin
      @(negedge clk_sys);
      bus_ack = 1'b0;
      if (rst || !bus_req) begin
        cnt = 0;
      end else if (ack_en && cnt >= ack_delay) begin
        bus_ack   = 1'b1;
        bus_rdata = bus_we ? 8'h00 : mem[bus_addr];
        t.we      = bus_we;
        t.addr    = bus_addr;
        t.wdata   = bus_we ? bus_wdata : 8'h00;
        obs_q.push_back(t);
        cnt = 0;
      end else begin
        cnt++;
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic exp_txn(input bit we, input int a, input logic [7:0] d);
    txn_t t;
    t.we    = we;
    t.addr  = 16'(a);
    t.wdata = we ? d : 8'h00;
    exp_q.push_back(t);
  endtask

  task automatic check_txns(input string tag);
    chk({tag, "_count"}, 32'(obs_q.size()), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++)
      chk(tag, 32'(obs_q[i]), 32'(exp_q[i]));
    obs_q.delete();
    exp_q.delete();
  endtask

  task automatic cs_begin();
    cs_n = 1'b0;
    repeat (4) @(negedge clk_sys);
  endtask

  task automatic send_byte(input logic [7:0] b);
    rx_ready = 1'b1;
    rx_data  = b;
    @(negedge clk_sys);
    rx_ready = 1'b0;
    repeat (GAP) @(negedge clk_sys);
  endtask

  task automatic cs_end();
    for (int i = 0; i < 100 && bus_req; i++) @(negedge clk_sys);
    cs_n = 1'b1;
    repeat (6) @(negedge clk_sys);
    chk("idle_tx", 32'(tx_data), 0);
    chk("idle_busy", 32'(busy), 0);
  endtask

  task automatic do_write(input int a, input string tag);
    cs_begin();
    send_byte(8'h01);
    send_byte(8'(a >> 8));
    send_byte(8'(a));
    for (int i = 0; i < wbuf.size(); i++) begin
      exp_txn(1'b1, a + i, wbuf[i]);
      send_byte(wbuf[i]);
    end
    cs_end();
    check_txns(tag);
  endtask

  task automatic do_read(input int a, input int n, input string tag);
    cs_begin();
    send_byte(8'h02);
    send_byte(8'(a >> 8));
    send_byte(8'(a));
    exp_txn(1'b0, a, 8'h00);
    chk({tag, "_tx0"}, 32'(tx_data), 32'(mem[16'(a)]));
    for (int k = 1; k <= n; k++) begin
      send_byte(8'($urandom));
      exp_txn(1'b0, a + k, 8'h00);
      chk({tag, "_tx"}, 32'(tx_data), 32'(mem[16'(a + k)]));
    end
    cs_end();
    check_txns(tag);
  endtask

  task automatic do_status(input bit with_clear, input string tag);
    cs_begin();
    if (with_clear) begin
      send_byte(8'h04);
      m_err = 1'b0;
      m_ovr = 1'b0;
    end
    send_byte(8'h03);
    chk(tag, 32'(tx_data), (m_ovr ? 2 : 0) + (m_err ? 1 : 0));
    cs_end();
  endtask

  initial begin : stimulus
    int a, n, tmo_len;
    rst       = 1'b1;
    cs_n      = 1'b1;
    rx_ready  = 1'b0;
    rx_data   = 8'h00;
    ack_en    = 1'b1;
    ack_delay = 0;
    m_err     = 1'b0;
    m_ovr     = 1'b0;
    for (int i = 0; i < 65536; i++) mem[i] = 8'($urandom);
    mem[16'h0010] = 8'h5A;
    mem[16'h0011] = 8'h6B;

    repeat (5) @(negedge clk_sys);
    chk("rst_tx", 32'(tx_data), 0);
    chk("rst_req", 32'(bus_req), 0);
    chk("rst_we", 32'(bus_we), 0);
    chk("rst_addr", 32'(bus_addr), 0);
    chk("rst_wdata", 32'(bus_wdata), 0);
    chk("rst_busy", 32'(busy), 0);
    rst = 1'b0;
    repeat (3) @(negedge clk_sys);

    wbuf = '{8'hAA, 8'hBB, 8'hCC};
    do_write(32'h1234, "wr_burst");
    do_status(1'b0, "st_after_wr");

    do_read(32'h0010, 2, "rd_burst");

    for (int r = 0; r < 6; r++) begin
      a         = (r == 2 || r == 3) ? 32'hFFFE : int'($urandom_range(0, 65535));
      n         = int'($urandom_range(1, 4));
      ack_delay = int'($urandom_range(0, 3));
      if (r % 2 == 0) begin
        wbuf.delete();
        for (int i = 0; i < n; i++) wbuf.push_back(8'($urandom));
        do_write(a, "rnd_wr");
      end else begin
        do_read(a, n, "rnd_rd");
      end
    end
    ack_delay = 0;

    wbuf = '{8'h11, 8'h22};
    do_write(32'hFFFF, "wrap");

    cs_begin();
    send_byte(8'h01);
    send_byte(8'hFF);
    cs_end();
    check_txns("abort");
    do_status(1'b0, "st_after_abort");

    cs_begin();
    send_byte(8'h7E);
    m_err = 1'b1;
    send_byte(8'h01);
    send_byte(8'h12);
    send_byte(8'h34);
    send_byte(8'h56);
    cs_end();
    check_txns("illegal");
    do_status(1'b0, "st_err");
    do_status(1'b1, "st_clear");

    // Each ack lands in the same cycle as the next data byte.
    ack_delay = GAP;
    wbuf = '{8'hA1, 8'hA2, 8'hA3};
    do_write(32'h5000, "ack_rx_same");
    ack_delay = 0;
    do_status(1'b0, "st_no_ovr");

    ack_delay = 30;
    cs_begin();
    send_byte(8'h01);
    send_byte(8'h20);
    send_byte(8'h00);
    exp_txn(1'b1, 32'h2000, 8'hD0);
    send_byte(8'hD0);
    m_ovr = 1'b1;
    send_byte(8'hD1);
    exp_txn(1'b1, 32'h2001, 8'hD2);
    send_byte(8'hD2);
    cs_end();
    check_txns("overrun");
    ack_delay = 0;
    do_status(1'b0, "st_ovr");

    ack_en = 1'b0;
    cs_begin();
    send_byte(8'h01);
    send_byte(8'h30);
    send_byte(8'h00);
    rx_ready = 1'b1;
    rx_data  = 8'hEE;
    @(negedge clk_sys);
    rx_ready = 1'b0;
    chk("tmo_req", 32'(bus_req), 1);
    chk("tmo_we", 32'(bus_we), 1);
    chk("tmo_addr", 32'(bus_addr), 32'h3000);
    chk("tmo_wdata", 32'(bus_wdata), 32'hEE);
    tmo_len = 0;
    for (int i = 0; i < 200 && bus_req === 1'b1; i++) begin
      tmo_len++;
      @(negedge clk_sys);
    end
    chk("tmo_len", 32'(tmo_len), ACK_TIMEOUT);
    m_err = 1'b1;
    send_byte(8'h99);
    chk("discard_req", 32'(bus_req), 0);
    cs_end();
    ack_en = 1'b1;
    check_txns("timeout");
    do_status(1'b0, "st_tmo");

    ack_en = 1'b0;
    cs_begin();
    send_byte(8'h01);
    send_byte(8'h40);
    send_byte(8'h00);
    rx_ready = 1'b1;
    rx_data  = 8'h55;
    @(negedge clk_sys);
    rx_ready = 1'b0;
    chk("mid_req", 32'(bus_req), 1);
    rst = 1'b1;
    @(negedge clk_sys);
    chk("mid_rst_req", 32'(bus_req), 0);
    chk("mid_rst_tx", 32'(tx_data), 0);
    chk("mid_rst_busy", 32'(busy), 0);
    rst  = 1'b0;
    cs_n = 1'b1;
    m_err = 1'b0;
    m_ovr = 1'b0;
    repeat (6) @(negedge clk_sys);
    ack_en = 1'b1;
    check_txns("reset");
    do_status(1'b0, "st_after_rst");

    wbuf = '{8'h01, 8'h02};
    do_write(32'h7FFF, "post_rst_wr");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
